// File: rtl/usb_multi_port_line_monitor_if.sv
// Line samples in, per-port line status out; compile with +define+USB_LINE_ERROR_EN to enable SE1 tracking.
// master = line/stimulus side, slave = the monitor.
interface usb_multi_port_line_monitor_if #(
  parameter int NUM_PORTS = 4
);
  logic [2*NUM_PORTS-1:0] usb_signals;
  logic [NUM_PORTS-1:0]   bus_reset;
  logic [NUM_PORTS-1:0]   reset_done;
  logic [NUM_PORTS-1:0]   speed_valid;
  logic [NUM_PORTS-1:0]   low_speed;
  logic [2*NUM_PORTS-1:0] j_state;
  logic [2*NUM_PORTS-1:0] k_state;
  logic [NUM_PORTS-1:0]   suspend;
  logic [NUM_PORTS-1:0]   resume;
  logic [NUM_PORTS-1:0]   line_error;

  modport master (
    output usb_signals,
    input  bus_reset, reset_done, speed_valid, low_speed, j_state, k_state,
           suspend, resume, line_error
  );

  modport slave (
    input  usb_signals,
    output bus_reset, reset_done, speed_valid, low_speed, j_state, k_state,
           suspend, resume, line_error
  );
endinterface

// File: rtl/usb_multi_port_line_monitor.sv
// Per-port USB line monitor: bus reset, J/K learning, suspend/resume; USB_LINE_ERROR_EN adds sticky SE1 flag.
// Latency: sample on edge N is reflected on the registered outputs right after edge N.
// No backpressure: every port consumes one line sample per clock.
module usb_multi_port_line_monitor #(
  parameter int NUM_PORTS       = 4,
  parameter int RESET_TIMER     = 20,
  parameter int SUSPEND_TIMER   = 200,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic clock,
  input logic reset_n,
  usb_multi_port_line_monitor_if.slave bus
);
  localparam int SW = $clog2(RESET_TIMER + 1);
  localparam int RW = $clog2(SUSPEND_TIMER + 1);
  localparam logic [SW-1:0] SE0_MAX = SW'(RESET_TIMER);
  localparam logic [RW-1:0] RUN_MAX = RW'(SUSPEND_TIMER);
  localparam logic [RW-1:0] DEB_MAX = RW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);
  localparam logic [1:0]    LINE_SE0 = 2'b00;
  localparam logic [1:0]    LINE_SE1 = 2'b11;

  typedef enum logic [1:0] {DETECT, IDLE, BUS_RESET, SUSPEND} state_t;

  logic [NUM_PORTS-1:0]   bus_reset_v, reset_done_v, speed_valid_v, low_speed_v;
  logic [NUM_PORTS-1:0]   suspend_v, resume_v, line_error_v;
  logic [2*NUM_PORTS-1:0] j_state_v, k_state_v;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    state_t        state_q, state_d;
    logic [SW-1:0] se0_q, se0_d, se0_inc;
    logic [RW-1:0] run_q, run_d, run_inc, det_cnt;
    logic [1:0]    val_q, val_d, j_q, j_d, k_q, k_d, s;
    logic          ls_q, ls_d, sv_q, sv_d, br_q, br_d, rd_q, rd_d;
    logic          sus_q, sus_d, res_q, res_d;
    logic          jk, se0_hit, do_detect, enter_reset;

    assign s       = bus.usb_signals[2*i +: 2];
    assign jk      = (s != LINE_SE0) && (s != LINE_SE1);
    assign se0_inc = (se0_q == SE0_MAX) ? SE0_MAX : se0_q + 1'b1;
    assign run_inc = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
    assign se0_hit = (s == LINE_SE0) && (se0_inc == SE0_MAX);
    // val_q remembers which J candidate the debounce run is counting
    assign det_cnt = ((run_q != '0) && (val_q == s)) ? run_inc : RUN_ONE;

    always_comb begin
      state_d     = state_q;
      se0_d       = (s == LINE_SE0) ? se0_inc : '0;
      run_d       = run_q;
      val_d       = val_q;
      j_d         = j_q;
      k_d         = k_q;
      ls_d        = ls_q;
      sv_d        = sv_q;
      br_d        = br_q;
      rd_d        = 1'b0;
      sus_d       = sus_q;
      res_d       = 1'b0;
      do_detect   = 1'b0;
      enter_reset = 1'b0;

      unique case (state_q)
        DETECT: do_detect = 1'b1;
        BUS_RESET: begin
          // SE1 is not a valid exit; the exit sample doubles as debounce sample one
          if (jk) begin
            br_d      = 1'b0;
            rd_d      = 1'b1;
            state_d   = DETECT;
            do_detect = 1'b1;
          end
        end
        IDLE: begin
          if (se0_hit) begin
            enter_reset = 1'b1;
          end else if (s == j_q) begin
            run_d = run_inc;
            if (run_inc == RUN_MAX) begin
              state_d = SUSPEND;
              sus_d   = 1'b1;
              run_d   = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        SUSPEND: begin
          if (se0_hit) begin
            enter_reset = 1'b1;
          end else if (s == k_q) begin
            run_d = run_inc;
            if (run_inc == DEB_MAX) begin
              state_d = IDLE;
              sus_d   = 1'b0;
              res_d   = 1'b1;
              run_d   = '0;
            end
          end else begin
            run_d = '0;
          end
        end
      endcase

      if (do_detect) begin
        if (se0_hit) begin
          enter_reset = 1'b1;
        end else if (jk) begin
          run_d = det_cnt;
          val_d = s;
          if (det_cnt == DEB_MAX) begin
            j_d     = s;
            k_d     = ~s;
            ls_d    = (s == 2'b01);
            sv_d    = 1'b1;
            state_d = IDLE;
            run_d   = '0;
          end
        end else begin
          run_d = '0;
        end
      end

      if (enter_reset) begin
        state_d = BUS_RESET;
        br_d    = 1'b1;
        sv_d    = 1'b0;
        sus_d   = 1'b0;
        ls_d    = 1'b0;
        j_d     = '0;
        k_d     = '0;
        run_d   = '0;
      end
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        state_q <= DETECT;
        se0_q   <= '0;
        run_q   <= '0;
        val_q   <= '0;
        j_q     <= '0;
        k_q     <= '0;
        ls_q    <= 1'b0;
        sv_q    <= 1'b0;
        br_q    <= 1'b0;
        rd_q    <= 1'b0;
        sus_q   <= 1'b0;
        res_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        se0_q   <= se0_d;
        run_q   <= run_d;
        val_q   <= val_d;
        j_q     <= j_d;
        k_q     <= k_d;
        ls_q    <= ls_d;
        sv_q    <= sv_d;
        br_q    <= br_d;
        rd_q    <= rd_d;
        sus_q   <= sus_d;
        res_q   <= res_d;
      end
    end

`ifdef USB_LINE_ERROR_EN
    logic se1_q, le_q;
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        se1_q <= 1'b0;
        le_q  <= 1'b0;
      end else begin
        se1_q <= (s == LINE_SE1);
        if (enter_reset) begin
          le_q <= 1'b0;
        end else if ((s == LINE_SE1) && se1_q) begin
          le_q <= 1'b1;
        end
      end
    end
    assign line_error_v[i] = le_q;
`else
    assign line_error_v[i] = 1'b0;
`endif

    assign bus_reset_v[i]      = br_q;
    assign reset_done_v[i]     = rd_q;
    assign speed_valid_v[i]    = sv_q;
    assign low_speed_v[i]      = ls_q;
    assign suspend_v[i]        = sus_q;
    assign resume_v[i]         = res_q;
    assign j_state_v[2*i +: 2] = j_q;
    assign k_state_v[2*i +: 2] = k_q;
  end

  assign bus.bus_reset   = bus_reset_v;
  assign bus.reset_done  = reset_done_v;
  assign bus.speed_valid = speed_valid_v;
  assign bus.low_speed   = low_speed_v;
  assign bus.j_state     = j_state_v;
  assign bus.k_state     = k_state_v;
  assign bus.suspend     = suspend_v;
  assign bus.resume      = resume_v;
  assign bus.line_error  = line_error_v;
endmodule

// File: tb/tb_usb_multi_port_line_monitor.sv
// Scoreboard bench: per-cycle expected outputs from a run-length model are queued and checked by a monitor.
module tb_usb_multi_port_line_monitor;
  localparam int N     = 4;
  localparam int RST_T = 20;
  localparam int SUS_T = 200;
  localparam int DEB   = 4;

  typedef struct packed {
    logic [N-1:0]   br, rd, sv, ls;
    logic [2*N-1:0] j, k;
    logic [N-1:0]   sus, res, le;
  } out_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  usb_multi_port_line_monitor_if #(.NUM_PORTS(N)) ifc();

  usb_multi_port_line_monitor #(
    .NUM_PORTS(N), .RESET_TIMER(RST_T), .SUSPEND_TIMER(SUS_T), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(ifc)
  );

  int passed = 0;
  int total  = 0;
  out_t exp_q[$];
  logic [1:0] scr[N][$];
  logic [1:0] cur[N];

  // Behavioural model: unbounded run lengths plus a few status flags per port
  bit         in_rst[N], learned[N], susp[N], se1_prev[N], lerr[N];
  logic [1:0] jv[N], last[N];
  int         se0_run[N], run[N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, want);
  endtask

  task automatic model_step(input bit rst_low);
    out_t e;
    logic [1:0] s;
    bit jk, rd, rs;
    e = '0;
    for (int p = 0; p < N; p++) begin
      s = cur[p];
      rd = 1'b0;
      rs = 1'b0;
      if (rst_low) begin
        in_rst[p] = 0; learned[p] = 0; susp[p] = 0; se1_prev[p] = 0; lerr[p] = 0;
        jv[p] = 2'b00; last[p] = 2'b00; se0_run[p] = 0; run[p] = 0;
      end else begin
        jk = (s == 2'b10) || (s == 2'b01);
        se0_run[p] = (s == 2'b00) ? se0_run[p] + 1 : 0;
`ifdef USB_LINE_ERROR_EN
        if (s == 2'b11 && se1_prev[p]) lerr[p] = 1;
`endif
        se1_prev[p] = (s == 2'b11);
        if (in_rst[p] && jk) begin
          in_rst[p] = 0;
          rd = 1'b1;
        end
        if (in_rst[p]) begin
          // held in bus reset
        end else if (se0_run[p] >= RST_T) begin
          in_rst[p] = 1; learned[p] = 0; susp[p] = 0; jv[p] = 2'b00; run[p] = 0; lerr[p] = 0;
        end else if (!learned[p]) begin
          if (jk) begin
            run[p] = (run[p] > 0 && last[p] == s) ? run[p] + 1 : 1;
            last[p] = s;
            if (run[p] == DEB) begin
              learned[p] = 1; jv[p] = s; run[p] = 0;
            end
          end else run[p] = 0;
        end else if (susp[p]) begin
          if (s == ~jv[p]) begin
            run[p]++;
            if (run[p] == DEB) begin
              susp[p] = 0; rs = 1'b1; run[p] = 0;
            end
          end else run[p] = 0;
        end else begin
          if (s == jv[p]) begin
            run[p]++;
            if (run[p] == SUS_T) begin
              susp[p] = 1; run[p] = 0;
            end
          end else run[p] = 0;
        end
      end
      e.br[p]        = in_rst[p];
      e.rd[p]        = rd;
      e.sv[p]        = learned[p];
      e.ls[p]        = learned[p] && (jv[p] == 2'b01);
      e.j[2*p +: 2]  = jv[p];
      e.k[2*p +: 2]  = learned[p] ? ~jv[p] : 2'b00;
      e.sus[p]       = susp[p];
      e.res[p]       = rs;
      e.le[p]        = lerr[p];
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit rst_low);
    @(negedge clock);
    reset_n = !rst_low;
    for (int p = 0; p < N; p++) begin
      if (scr[p].size() > 0) cur[p] = scr[p].pop_front();
      ifc.usb_signals[2*p +: 2] = cur[p];
    end
    model_step(rst_low);
  endtask

  task automatic add(input int p, input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) scr[p].push_back(v);
  endtask

  task automatic run_scripts();
    bit busy;
    busy = 1'b1;
    while (busy) begin
      busy = 1'b0;
      for (int p = 0; p < N; p++) if (scr[p].size() > 0) busy = 1'b1;
      if (busy) cycle(1'b0);
    end
  endtask

  task automatic random_fill(input int len_per_port);
    logic [1:0] pref, v;
    int len, t, n;
    for (int p = 0; p < N; p++) begin
      pref = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      len = 0;
      while (len < len_per_port) begin
        t = $urandom_range(0, 99);
        if (t < 35) begin v = pref; n = $urandom_range(1, 230); end
        else if (t < 55) begin v = ~pref; n = $urandom_range(1, 6); end
        else if (t < 70) begin
          v = 2'b00; n = $urandom_range(1, 26);
          if (n >= RST_T && $urandom_range(0, 1) != 0) pref = ~pref;
        end
        else if (t < 80) begin v = 2'b11; n = $urandom_range(1, 3); end
        else begin v = pref; n = $urandom_range(1, 8); end
        add(p, v, n);
        len += n;
      end
    end
  endtask

  // Monitor: outputs are compared one time unit after each active edge
  initial begin
    out_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bus_reset",   32'(ifc.bus_reset),   32'(e.br));
        chk("reset_done",  32'(ifc.reset_done),  32'(e.rd));
        chk("speed_valid", 32'(ifc.speed_valid), 32'(e.sv));
        chk("low_speed",   32'(ifc.low_speed),   32'(e.ls));
        chk("j_state",     32'(ifc.j_state),     32'(e.j));
        chk("k_state",     32'(ifc.k_state),     32'(e.k));
        chk("suspend",     32'(ifc.suspend),     32'(e.sus));
        chk("resume",      32'(ifc.resume),      32'(e.res));
        chk("line_error",  32'(ifc.line_error),  32'(e.le));
      end
    end
  end

  initial begin
    ifc.usb_signals = '0;
    for (int p = 0; p < N; p++) cur[p] = 2'b00;
    repeat (3) cycle(1'b1);

    // Port0: FS learn, then SE1 single/double, then bus reset clears the error flag
    add(0, 2'b10, 14); add(0, 2'b11, 1); add(0, 2'b10, 3); add(0, 2'b11, 2);
    add(0, 2'b10, 10); add(0, 2'b00, 20); add(0, 2'b10, 6);
    // Port1: LS learn, full bus reset, relearn, then a 19-sample SE0 that must not reset
    add(1, 2'b01, 6); add(1, 2'b00, 20); add(1, 2'b01, 6); add(1, 2'b00, 19); add(1, 2'b01, 5);
    // Port2: FS learn, suspend, short K (no resume), then a full resume
    add(2, 2'b10, 204); add(2, 2'b01, 3); add(2, 2'b10, 1); add(2, 2'b01, 4); add(2, 2'b10, 10);
    // Port3: suspend, then reset-from-suspend held in SE0
    add(3, 2'b10, 204); add(3, 2'b00, 23);
    run_scripts();
    cycle(1'b1);
    repeat (5) cycle(1'b0);

    // All ports with independent random line activity, one reset pulse in the middle
    random_fill(1200);
    run_scripts();
    cycle(1'b1);
    random_fill(1200);
    run_scripts();

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
